// File: rtl/prefix_carry_pipe_4b_pkg.sv
// Shared constants and types for the 4-bit parallel-prefix adder slice.
package prefix_carry_pipe_4b_pkg;

    localparam int ADD_WIDTH = 4;

    typedef logic [ADD_WIDTH:0] pg_vec_t;

    typedef struct packed {
        logic g;
        logic p;
    } pg_pair_t;

endpackage

// File: rtl/prefix_carry_pipe_4b_prefix_cell.sv
// Kogge-Stone black cell: merges a (g,p) pair with the pair one span below it.
module prefix_cell
    import prefix_carry_pipe_4b_pkg::*;
(
    input  logic     g_hi,
    input  logic     p_hi,
    input  logic     g_lo,
    input  logic     p_lo,
    output pg_pair_t res
);

    assign res.g = g_hi | (p_hi & g_lo);
    assign res.p = p_hi & p_lo;

endmodule

// File: rtl/prefix_carry_pipe_4b.sv
// Two-stage Kogge-Stone carry network plus sum post-processing for the 4-bit
// prefix adder, with a valid/ready handshake and full backpressure.
module prefix_carry_pipe_4b
    import prefix_carry_pipe_4b_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADD_WIDTH:0]   prop_i,
    input  logic [ADD_WIDTH:0]   gen_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic [ADD_WIDTH-1:0] sum_o,
    output logic                 carry_o,
    output logic                 group_prop_o,
    output logic                 valid_o,
    input  logic                 ready_i
);

    pg_vec_t                p_in;
    pg_pair_t [ADD_WIDTH:0] lvl0;
    pg_pair_t [ADD_WIDTH:0] lvl1;
    pg_pair_t [ADD_WIDTH:0] lvl2;

    logic                   s1_en;
    logic                   s2_en;
    logic                   vld_p1;
    logic                   vld_p2;
    pg_pair_t [ADD_WIDTH:0] pg_p1;
    logic [ADD_WIDTH-1:0]   prop_p1;

    pg_pair_t               lvl3_top;
    pg_vec_t                carry_vec;
    logic                   low_p;
    logic                   group_prop;

    logic [ADD_WIDTH-1:0]   sum_p2;
    logic                   carry_p2;
    logic                   group_prop_p2;

    // Position 0 holds the carry-in as a pure generate term, so its propagate is tied low.
    assign p_in = {prop_i[ADD_WIDTH:1], prop_i[0] & 1'b0};

    always_comb begin
        lvl0 = '0;
        for (int k = 0; k <= ADD_WIDTH; k++) begin
            lvl0[k].g = gen_i[k];
            lvl0[k].p = p_in[k];
        end
    end

    assign lvl1[0] = lvl0[0];
    assign lvl2[0] = lvl1[0];
    assign lvl2[1] = lvl1[1];

    for (genvar i = 1; i <= ADD_WIDTH; i++) begin : g_lvl1
        prefix_cell u_cell (
            .g_hi (lvl0[i].g),
            .p_hi (lvl0[i].p),
            .g_lo (lvl0[i-1].g),
            .p_lo (lvl0[i-1].p),
            .res  (lvl1[i])
        );
    end

    for (genvar i = 2; i <= ADD_WIDTH; i++) begin : g_lvl2
        prefix_cell u_cell (
            .g_hi (lvl1[i].g),
            .p_hi (lvl1[i].p),
            .g_lo (lvl1[i-2].g),
            .p_lo (lvl1[i-2].p),
            .res  (lvl2[i])
        );
    end

    assign s2_en   = !vld_p2 | ready_i;
    assign s1_en   = !vld_p1 | s2_en;
    assign ready_o = s1_en & !rst_i;

    // Stage 1: level-2 prefix pairs and raw operand propagates
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            pg_p1   <= '0;
            prop_p1 <= '0;
        end else if (s1_en) begin
            vld_p1  <= valid_i & ready_o;
            pg_p1   <= lvl2;
            prop_p1 <= prop_i[ADD_WIDTH:1];
        end
    end

    prefix_cell u_lvl3 (
        .g_hi (pg_p1[ADD_WIDTH].g),
        .p_hi (pg_p1[ADD_WIDTH].p),
        .g_lo (pg_p1[0].g),
        .p_lo (pg_p1[0].p),
        .res  (lvl3_top)
    );

    // With p[0] tied low every lower-position P is zero, so this reduces to the
    // level-2 P at the top position, which already spans p[4:1].
    always_comb begin
        carry_vec = '0;
        low_p     = 1'b0;
        for (int k = 0; k < ADD_WIDTH; k++) begin
            carry_vec[k] = pg_p1[k].g;
            low_p        = low_p | pg_p1[k].p;
        end
        carry_vec[ADD_WIDTH] = lvl3_top.g;
        group_prop = pg_p1[ADD_WIDTH].p & !low_p & !lvl3_top.p;
    end

    // Stage 2: sum, carry-out and group propagate
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p2        <= 1'b0;
            sum_p2        <= '0;
            carry_p2      <= 1'b0;
            group_prop_p2 <= 1'b0;
        end else if (s2_en) begin
            vld_p2        <= vld_p1;
            sum_p2        <= prop_p1 ^ carry_vec[ADD_WIDTH-1:0];
            carry_p2      <= carry_vec[ADD_WIDTH];
            group_prop_p2 <= group_prop;
        end
    end

    assign sum_o        = sum_p2;
    assign carry_o      = carry_p2;
    assign group_prop_o = group_prop_p2;
    assign valid_o      = vld_p2;

endmodule

// File: tb/tb_prefix_carry_pipe_4b.sv
// Directed bench for prefix_carry_pipe_4b: latency, backpressure, reset and sum sweep.
module tb_prefix_carry_pipe_4b;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] prop_i = '0;
    logic [4:0] gen_i = '0;
    logic       valid_i = 1'b0;
    logic       ready_i = 1'b0;
    logic       ready_o;
    logic [3:0] sum_o;
    logic       carry_o;
    logic       group_prop_o;
    logic       valid_o;

    int         n_assert = 0;
    int         n_fail = 0;
    int         n_pop = 0;
    logic [5:0] exp_q[$];
    logic [5:0] pending;

    always #5 clk = ~clk;

    prefix_carry_pipe_4b dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .prop_i       (prop_i),
        .gen_i        (gen_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .sum_o        (sum_o),
        .carry_o      (carry_o),
        .group_prop_o (group_prop_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected word is {group_prop, carry, sum[3:0]}, computed arithmetically.
    task automatic set_beat(input logic [3:0] a, input logic [3:0] b, input logic cin,
                            input logic pbit0);
        logic [4:0] s;
        s       = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        prop_i  = {a ^ b, pbit0};
        gen_i   = {a & b, cin};
        valid_i = 1'b1;
        pending = {((a ^ b) == 4'hf), s};
    endtask

    // Called at a falling edge with inputs set; resolves both handshakes, then advances one cycle.
    task automatic cycle();
        #1;
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("spurious_result", 8'd1, 8'd0);
            end else begin
                chk("result", {2'b0, group_prop_o, carry_o, sum_o}, {2'b0, exp_q.pop_front()});
                n_pop++;
            end
        end
        if (valid_i && ready_o) exp_q.push_back(pending);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic latency_test(input string tag, input logic [3:0] a, input logic [3:0] b,
                                input logic cin, input logic pbit0);
        logic [5:0] e;
        ready_i = 1'b1;
        set_beat(a, b, cin, pbit0);
        e = pending;
        cycle();
        valid_i = 1'b0;
        #1 chk({tag, "_not_yet"}, {7'b0, valid_o}, 8'd0);
        cycle();
        #1 chk({tag, "_valid"}, {7'b0, valid_o}, 8'd1);
        chk({tag, "_data"}, {2'b0, group_prop_o, carry_o, sum_o}, {2'b0, e});
        cycle();
    endtask

    initial begin
        int         pops_before;
        logic       acc;
        int         tries;
        logic [3:0] ra, rb;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_ready", {7'b0, ready_o}, 8'd0);
        chk("rst_valid", {7'b0, valid_o}, 8'd0);
        chk("rst_data", {2'b0, group_prop_o, carry_o, sum_o}, 8'd0);
        rst_i = 1'b0;
        #1 chk("post_rst_ready", {7'b0, ready_o}, 8'd1);
        @(negedge clk);

        // 11+6 cin=0 -> sum 1, carry 1, gp 0
        latency_test("add_11_6", 4'd11, 4'd6, 1'b0, 1'b0);
        chk("add_11_6_prop", {3'b0, 5'b11010}, {3'b0, prop_i});
        // 15+0 cin=1 -> sum 0, carry 1, gp 1; bit 0 of prop_i ignored
        latency_test("add_15_0", 4'd15, 4'd0, 1'b1, 1'b0);
        latency_test("add_15_0_p0", 4'd15, 4'd0, 1'b1, 1'b1);

        // Eight back-to-back random beats
        ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                ra = 4'($urandom_range(0, 15));
                rb = 4'($urandom_range(0, 15));
                set_beat(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                valid_i = 1'b0;
            end
            if (k >= 2) begin
                #1 chk("b2b_valid", {7'b0, valid_o}, 8'd1);
            end
            cycle();
        end
        chk("b2b_drained", 8'(exp_q.size()), 8'd0);

        // Backpressure: two held, third refused until ready_i rises
        pops_before = n_pop;
        ready_i = 1'b0;
        set_beat(4'd3, 4'd4, 1'b0, 1'b0);
        #1 chk("bp_accept1", {7'b0, ready_o}, 8'd1);
        cycle();
        set_beat(4'd9, 4'd9, 1'b1, 1'b0);
        #1 chk("bp_accept2", {7'b0, ready_o}, 8'd1);
        cycle();
        set_beat(4'd14, 4'd7, 1'b1, 1'b0);
        #1 chk("bp_full_ready", {7'b0, ready_o}, 8'd0);
        chk("bp_full_valid", {7'b0, valid_o}, 8'd1);
        cycle();
        #1 chk("bp_still_full", {7'b0, ready_o}, 8'd0);
        cycle();
        ready_i = 1'b1;
        #1 chk("bp_release_ready", {7'b0, ready_o}, 8'd1);
        cycle();
        valid_i = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        chk("bp_results", 8'(n_pop - pops_before), 8'd3);
        chk("bp_drained", 8'(exp_q.size()), 8'd0);

        // Asynchronous reset with two beats in flight
        set_beat(4'd1, 4'd2, 1'b0, 1'b0);
        cycle();
        set_beat(4'd5, 4'd5, 1'b0, 1'b0);
        cycle();
        valid_i = 1'b0;
        #1 chk("pre_reset_valid", {7'b0, valid_o}, 8'd1);
        #1 rst_i = 1'b1;
        #1;
        chk("mid_reset_valid", {7'b0, valid_o}, 8'd0);
        chk("mid_reset_ready", {7'b0, ready_o}, 8'd0);
        chk("mid_reset_data", {2'b0, group_prop_o, carry_o, sum_o}, 8'd0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #1 chk("reset_held_ready", {7'b0, ready_o}, 8'd0);
        rst_i = 1'b0;
        #1 chk("reset_release_ready", {7'b0, ready_o}, 8'd1);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            #1 chk("no_stale", {7'b0, valid_o}, 8'd0);
            @(posedge clk);
            @(negedge clk);
        end
        latency_test("after_reset", 4'd8, 4'd8, 1'b1, 1'b0);

        // Exhaustive sweep with random downstream stalls
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    set_beat(4'(a), 4'(b), 1'(c), 1'(a[0]));
                    tries = 0;
                    do begin
                        ready_i = 1'($urandom_range(0, 1));
                        #1 acc = ready_o;
                        cycle();
                        tries++;
                    end while (!acc && tries < 64);
                    chk("sweep_accept", {7'b0, acc}, 8'd1);
                end
            end
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (exp_q.size() != 0) cycle();
        end
        chk("sweep_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
